// File: rtl/clkmon_pkg.sv
// Shared types for the clock monitor: FSM state encoding and fault codes.
package clkmon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        TRACK   = 3'd2,
        LOCKED  = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_FAST  = 2'b01;
    localparam logic [1:0] FLT_SLOW  = 2'b10;
    localparam logic [1:0] FLT_STUCK = 2'b11;

endpackage

// File: rtl/clkmon_sync.sv
// Two-flop synchroniser for the monitored clock followed by a registered
// edge detector; pulse is high for one clk cycle per mon_clk transition.
module clkmon_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_r;
    logic sync_r;

    // Synchronise din and flag any change of the synchronised level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            pulse  <= meta_r ^ sync_r;
        end
    end

endmodule

// File: rtl/clk_monitor.sv
// Generated-clock monitor: measures mon_clk half periods against clk, tracks lock
// and raises sticky faults. Define CLKMON_HIST_EN to add min_half/max_half outputs.
module clk_monitor
    import clkmon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int STUCK_MULT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_clk,
    input  logic [CNT_W-1:0] exp_half,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
`ifdef CLKMON_HIST_EN
    output logic [CNT_W-1:0] min_half,
    output logic [CNT_W-1:0] max_half,
`endif
    output logic [31:0]      edge_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = CNT_W + 1;
    localparam int SW = CNT_W + $clog2(STUCK_MULT + 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [GW-1:0]    good_r;
    logic [GW-1:0]    good_nxt_s;
    logic [1:0]       code_nxt_s;
    logic             edge_s;
    logic             take_s;
    logic             fast_s;
    logic             slow_s;
    logic             stuck_s;
    logic [SW-1:0]    stuck_lim_s;

    clkmon_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (mon_clk),
        .pulse (edge_s)
    );

    // Classification is done one bit wider so exp_half +/- TOL cannot wrap.
    assign fast_s      = ({1'b0, cnt_r} + EW'(TOL)) < {1'b0, exp_half};
    assign slow_s      = {1'b0, cnt_r} > ({1'b0, exp_half} + EW'(TOL));
    assign stuck_lim_s = SW'(STUCK_MULT) * SW'(exp_half);
    assign stuck_s     = SW'(cnt_r) >= stuck_lim_s;

    // Next-state, lock counter, fault code and measurement-accept decode.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        code_nxt_s  = fault_code;
        take_s      = 1'b0;
        if (!enable) begin
            state_nxt_s = IDLE;
            good_nxt_s  = '0;
            code_nxt_s  = FLT_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = ACQUIRE;
                    good_nxt_s  = '0;
                    code_nxt_s  = FLT_NONE;
                end
                ACQUIRE: begin
                    good_nxt_s = '0;
                    if (edge_s) begin
                        state_nxt_s = TRACK;
                    end else begin
                        state_nxt_s = ACQUIRE;
                    end
                end
                TRACK, LOCKED: begin
                    if (stuck_s || (edge_s && (fast_s || slow_s))) begin
                        good_nxt_s = '0;
                        // A clear arriving with the violation wins and drops the sample.
                        if (fault_clr) begin
                            state_nxt_s = ACQUIRE;
                            code_nxt_s  = FLT_NONE;
                        end else begin
                            state_nxt_s = FAULT;
                            take_s      = edge_s;
                            if (stuck_s) begin
                                code_nxt_s = FLT_STUCK;
                            end else if (fast_s) begin
                                code_nxt_s = FLT_FAST;
                            end else begin
                                code_nxt_s = FLT_SLOW;
                            end
                        end
                    end else if (edge_s) begin
                        take_s = 1'b1;
                        if (state_r == TRACK && good_r == GW'(LOCK_CNT - 1)) begin
                            state_nxt_s = LOCKED;
                            good_nxt_s  = GW'(LOCK_CNT);
                        end else if (state_r == TRACK) begin
                            good_nxt_s = good_r + GW'(1);
                        end else begin
                            good_nxt_s = good_r;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        state_nxt_s = ACQUIRE;
                        good_nxt_s  = '0;
                        code_nxt_s  = FLT_NONE;
                    end else begin
                        take_s = edge_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    good_nxt_s  = '0;
                    code_nxt_s  = FLT_NONE;
                end
            endcase
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            good_r      <= '0;
            cnt_r       <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FLT_NONE;
            edge_count  <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            good_r     <= good_nxt_s;
            fault_code <= code_nxt_s;
            locked     <= (state_nxt_s == LOCKED);
            fault      <= (state_nxt_s == FAULT);
            meas_valid <= take_s;
            if (edge_s && enable) begin
                edge_count <= edge_count + 32'd1;
            end
            if (!enable) begin
                cnt_r       <= '0;
                half_period <= '0;
            end else begin
                if (edge_s) begin
                    cnt_r <= CNT_W'(1);
                end else if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                if (take_s) begin
                    half_period <= cnt_r;
                end
            end
        end
    end

`ifdef CLKMON_HIST_EN
    logic hist_vld_r;

    // Running min/max of accepted measurements since the last clear.
    always_ff @(posedge clk) begin
        if (rst || !enable || fault_clr) begin
            hist_vld_r <= 1'b0;
            min_half   <= '0;
            max_half   <= '0;
        end else if (take_s) begin
            hist_vld_r <= 1'b1;
            if (!hist_vld_r || cnt_r < min_half) begin
                min_half <= cnt_r;
            end
            if (!hist_vld_r || cnt_r > max_half) begin
                max_half <= cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Randomised scoreboard bench for clk_monitor: expected measurements are derived
// from mon_clk toggle times and pushed to a queue checked by a separate monitor.
module tb_clk_monitor;
    import clkmon_pkg::*;

    localparam int CNT_W = 16;
    localparam int EXP   = 5;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;
    localparam int STUCK = 4 * EXP;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             mon_clk = 1'b0;
    logic [CNT_W-1:0] exp_half = 16'd5;
    logic             fault_clr = 1'b0;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_code;
    logic [31:0]      edge_count;
`ifdef CLKMON_HIST_EN
    logic [CNT_W-1:0] min_half;
    logic [CNT_W-1:0] max_half;
`endif

    clk_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mon_clk     (mon_clk),
        .exp_half    (exp_half),
        .fault_clr   (fault_clr),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .fault       (fault),
        .fault_code  (fault_code),
`ifdef CLKMON_HIST_EN
        .min_half    (min_half),
        .max_half    (max_half),
`endif
        .edge_count  (edge_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int m;
        bit lk;
        bit flt;
        int code;
        int mn;
        int mx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, kept in terms of toggle times rather than hardware state
    bit m_acq, m_fault, m_locked, m_hv;
    int m_good, m_code, m_last, m_edges, m_mn, m_mx;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        m_acq = 0; m_fault = 0; m_locked = 0; m_good = 0; m_code = 0; m_hv = 0;
        m_mn = 0; m_mx = 0;
    endtask

    task automatic model_edge(input int t);
        int gap;
        m_edges++;
        if (!m_acq) begin
            m_acq  = 1;
            m_last = t;
            return;
        end
        gap    = t - m_last;
        m_last = t;
        if (!m_fault) begin
            if (gap >= STUCK) begin
                m_fault = 1; m_code = 3; m_locked = 0; m_good = 0;
            end else if (gap < EXP - TOL) begin
                m_fault = 1; m_code = 1; m_locked = 0; m_good = 0;
            end else if (gap > EXP + TOL) begin
                m_fault = 1; m_code = 2; m_locked = 0; m_good = 0;
            end else if (!m_locked) begin
                m_good++;
                if (m_good == LOCKN) m_locked = 1;
            end
        end
        if (!m_hv) begin
            m_mn = gap; m_mx = gap; m_hv = 1;
        end else begin
            if (gap < m_mn) m_mn = gap;
            if (gap > m_mx) m_mx = gap;
        end
        q.push_back('{gap, m_locked, m_fault, m_code, m_mn, m_mx});
    endtask

    task automatic toggle_after(input int g);
        repeat (g) @(posedge clk);
        #1 mon_clk = ~mon_clk;
        model_edge(cyc);
    endtask

    task automatic clear_fault();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("fault_held", fault, 1);
        chk("code_held", fault_code, m_code);
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        model_clear();
        @(negedge clk);
        chk("fault_after_clr", fault, 0);
        chk("code_after_clr", fault_code, 0);
    endtask

    task automatic drop_enable();
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dis_fault", fault, 0);
        chk("dis_locked", locked, 0);
        chk("dis_half_period", half_period, 0);
        chk("dis_code", fault_code, 0);
        chk("dis_meas_valid", meas_valid, 0);
        chk("dis_edge_count", edge_count, m_edges);
        model_clear();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every meas_valid pops one expected measurement.
    always @(negedge clk) begin
        if (!rst && meas_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL meas_valid_unexpected actual=1 required=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("half_period", half_period, e.m);
                chk("locked", locked, e.lk);
                chk("fault", fault, e.flt);
                chk("fault_code", fault_code, e.code);
`ifdef CLKMON_HIST_EN
                chk("min_half", min_half, e.mn);
                chk("max_half", max_half, e.mx);
`endif
            end
        end
    end

    initial begin
        int r, g;
        model_clear();
        m_edges = 0;
        m_last  = 0;

        // Reset while mon_clk toggles
        repeat (3) begin
            @(posedge clk);
            #1 mon_clk = ~mon_clk;
        end
        @(negedge clk);
        chk("rst_half_period", half_period, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_edge_count", edge_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("idle_edge_count", edge_count, 0);
        chk("idle_locked", locked, 0);

        // Directed: lock, slow fault, relock, stuck, fast
        @(posedge clk);
        #1 enable = 1'b1;
        toggle_after(3);
        repeat (5) toggle_after(5);
        repeat (2) toggle_after(8);
        toggle_after(5);
        clear_fault();
        toggle_after(3);
        repeat (5) toggle_after(5);
        repeat (21) @(posedge clk);
        @(negedge clk);
        chk("stuck_early", fault, 0);
        chk("stuck_locked_early", locked, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stuck_fault", fault, 1);
        chk("stuck_code", fault_code, 3);
        chk("stuck_locked", locked, 0);
        m_fault = 1; m_code = 3; m_locked = 0; m_good = 0;
        toggle_after(2);
        clear_fault();
        toggle_after(3);
        repeat (2) toggle_after(5);
        toggle_after(3);
        clear_fault();
        toggle_after(4);
        drop_enable();

        // Randomised rounds
        for (int round = 0; round < 3; round++) begin
            @(posedge clk);
            #1 enable = 1'b1;
            for (int i = 0; i < 30; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6)       g = $urandom_range(4, 6);
                else if (r < 8)  g = $urandom_range(2, 9);
                else if (r == 8) g = 25;
                else             g = $urandom_range(2, 3);
                toggle_after(g);
                if (m_fault && $urandom_range(0, 2) == 0) clear_fault();
            end
            drop_enable();
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("final_edge_count", edge_count, m_edges);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
